demux_dispatch_queue: RTL and testbench
=======================================

Name: demux_dispatch_queue

Overview:
- Upstream feeder for the 8-bit 1-to-3 demux on the EMU_v8-1 internal bus.
- Buffers write requests, each a destination code plus an 8-bit data byte, in a small FIFO.
- Issues at most one request per cycle: drives the demux data and select lines and emits a one-hot load strobe to the selected destination register.
- Holds off a destination while it reports busy, and drops requests with an illegal code.

Parameters:
- DEPTH, 4, number of FIFO entries; power of two, 2 to 16.
- DW, 8, data width; matches the demux input.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- in_valid  in  1  request present.
- in_ready  out  1  queue can accept; equals !full.
- in_dest  in  2  destination: 01=Q1, 10=Q2, 11=Q3, 00=illegal.
- in_data  in  DW  byte to route.
- flush  in  1  synchronous clear of queued entries.
- dest_busy  in  3  bit k high = destination Q(k+1) cannot load this cycle.
- out_data  out  DW  to demux I.
- out_sel  out  2  to demux S.
- out_load  out  3  one-hot load strobe; bit k = Q(k+1).
- drop_err  out  1  one-cycle pulse when an illegal entry is discarded.
- drop_count  out  8  saturating count of discarded entries.
- count  out  $clog2(DEPTH)+1  current occupancy.
- empty  out  1  count==0.
- full  out  1  count==DEPTH.

Behaviour:
- Reset (async, any time, including mid-dispatch):
  - FIFO pointers and count go to 0; empty=1, full=0, in_ready=1.
  - out_data=0, out_sel=00, out_load=000, drop_err=0, drop_count=0.
  - A strobe in flight is cancelled immediately.
- Push: an entry is written on a rising edge where in_valid && in_ready && !flush.
  - Writes while full are never accepted. There is no bypass, even if a pop occurs in the same cycle.
- Head evaluation is combinational each cycle on the FIFO head when non-empty:
  - Head dest 00: pop; register drop_err=1 for one cycle; drop_count+1, saturating at 255; out_load=000; out_data and out_sel unchanged.
  - Head dest d≠00 and dest_busy[d-1]=0: pop; register out_data=head data, out_sel=d, out_load=one-hot(d) for exactly one cycle.
  - Head dest d≠00 and dest_busy[d-1]=1: no pop; out_load=000. Head-of-line blocking applies; later entries wait.
- Latency: an entry accepted at edge E, with its destination not busy and the FIFO previously empty, has out_load asserted from edge E+1 to E+2. Throughput is 1 entry per cycle.
- out_data and out_sel hold the last dispatched value while idle. The demux input therefore stays stable, and only the load strobe qualifies it.
- Simultaneous push and pop when not full: count unchanged; both take effect.
- Pointers wrap modulo DEPTH; count distinguishes full from empty.
- flush, synchronous with priority over push and pop:
  - pointers and count go to 0; any push that edge is ignored;
  - out_load=000 and drop_err=0 on the next cycle; out_data, out_sel and drop_count keep their values.
- Single controlling state machine:
  - IDLE: empty.
  - ISSUE: head dispatchable.
  - STALL: head blocked by busy.
  - IDLE→ISSUE/STALL on non-empty; ISSUE→STALL when the new head's destination is busy; STALL→ISSUE when busy clears; any state→IDLE on empty or flush.
  - State is derivable from count and busy. It is encoded explicitly for debug visibility.

Decomposition:
- Package emu_bus_pkg holds:
  - DEST_NONE=2'b00, DEST_Q1=2'b01, DEST_Q2=2'b10, DEST_Q3=2'b11;
  - dispatch state enum {IDLE, ISSUE, STALL};
  - request struct {dest[1:0], data[DW-1:0]}.
- Sub-module sync_fifo (DEPTH, width 2+DW; push, pop, flush, full, empty, count) holds the storage.
- The dispatch and strobe logic stays in the top level.

Test Plan:
- Reset, then push {01,0x05}, no busy: out_load=001, out_sel=01, out_data=0x05 one cycle after acceptance; count back to 0.
- Push {01,0x05},{10,0x05},{11,0x05},{11,0x0F} back-to-back: out_load sequence 001,010,100,100 on consecutive cycles; out_data last =0x0F.
- dest_busy=010 held 5 cycles, push {10,0xAA},{01,0x11}: no strobe while busy (HOL block), full never set. Release busy: 010 then 001 on consecutive cycles.
- With dest_busy=111, push 4 entries: full=1, in_ready=0, and a 5th push is ignored. Assert flush: count=0, empty=1, and no strobe follows busy release.
- Push {00,0x33} then {01,0x44}: drop_err pulses once, drop_count=1, no strobe for 0x33; 0x44 is routed with out_load=001. Repeat 300 illegal pushes: drop_count saturates at 255.
- Assert rst mid-stream with 3 entries queued and out_load=010: out_load=000 and count=0 immediately, without waiting for a clock edge; no stale strobe after rst deasserts.

Source files
------------

// File: rtl/emu_bus_pkg.sv
// Shared EMU_v8-1 internal-bus definitions: destination codes, dispatch
// states and the queued request layout.
package emu_bus_pkg;

  localparam int EMU_DW = 8;

  localparam logic [1:0] DEST_NONE = 2'b00;
  localparam logic [1:0] DEST_Q1   = 2'b01;
  localparam logic [1:0] DEST_Q2   = 2'b10;
  localparam logic [1:0] DEST_Q3   = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    STALL = 2'd2
  } dispatch_state_t;

  typedef struct packed {
    logic [1:0]        dest;
    logic [EMU_DW-1:0] data;
  } bus_req_t;

  function automatic logic [2:0] dest_onehot(input logic [1:0] dest);
    case (dest)
      DEST_Q1: return 3'b001;
      DEST_Q2: return 3'b010;
      DEST_Q3: return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Small register-based FIFO with a combinational head read, so the
// dispatcher can inspect the oldest entry in the same cycle it is popped.
module sync_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 10
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [W-1:0]             wr_data,
  output logic [W-1:0]             rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [CW-1:0] count_reg;
  logic          do_push;
  logic          do_pop;

  assign full  = (count_reg == CW'(DEPTH));
  assign empty = (count_reg == '0);
  assign count = count_reg;

  // Flush wins over both ports; a full FIFO never accepts, even alongside a pop.
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;

  assign rd_data = mem[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/demux_dispatch_queue.sv
// Request queue feeding the 1-to-3 bus demux: issues one queued write per
// cycle as a registered data/select pair plus a one-hot load strobe.
module demux_dispatch_queue
  import emu_bus_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int DW    = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [1:0]               in_dest,
  input  logic [DW-1:0]            in_data,
  input  logic                     flush,
  input  logic [2:0]               dest_busy,
  output logic [DW-1:0]            out_data,
  output logic [1:0]               out_sel,
  output logic [2:0]               out_load,
  output logic                     drop_err,
  output logic [7:0]               drop_count,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);

  logic [DW+1:0]   head;
  logic [1:0]      head_dest;
  logic [DW-1:0]   head_data;
  logic            fifo_pop;
  logic            blocked;

  dispatch_state_t state_reg;
  dispatch_state_t state_next;
  logic [2:0]      load_next;
  logic            drop_next;

  logic [DW-1:0]   out_data_reg;
  logic [1:0]      out_sel_reg;
  logic [2:0]      out_load_reg;
  logic            drop_err_reg;
  logic [7:0]      drop_count_reg;

  sync_fifo #(
    .DEPTH (DEPTH),
    .W     (DW + 2)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (in_valid),
    .pop     (fifo_pop),
    .flush   (flush),
    .wr_data ({in_dest, in_data}),
    .rd_data (head),
    .full    (full),
    .empty   (empty),
    .count   (count)
  );

  assign in_ready  = !full;
  assign head_dest = head[DW+1:DW];
  assign head_data = head[DW-1:0];

  // Illegal heads are never blocked; they are always discarded immediately.
  always_comb begin
    case (head_dest)
      DEST_Q1: blocked = dest_busy[0];
      DEST_Q2: blocked = dest_busy[1];
      DEST_Q3: blocked = dest_busy[2];
      default: blocked = 1'b0;
    endcase
  end

  // state_next is the operating state for this cycle; it drives the pop
  // and strobe decisions directly, and state_reg keeps it for debug.
  always_comb begin
    state_next = state_reg;
    fifo_pop   = 1'b0;
    load_next  = 3'b000;
    drop_next  = 1'b0;

    if (flush || empty) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE:    state_next = blocked ? STALL : ISSUE;
        ISSUE:   if (blocked) state_next = STALL;
        STALL:   if (!blocked) state_next = ISSUE;
        default: state_next = IDLE;
      endcase
    end

    if (state_next == ISSUE) begin
      fifo_pop = 1'b1;
      if (head_dest == DEST_NONE) begin
        drop_next = 1'b1;
      end else begin
        load_next = dest_onehot(head_dest);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= IDLE;
      out_data_reg   <= '0;
      out_sel_reg    <= DEST_NONE;
      out_load_reg   <= 3'b000;
      drop_err_reg   <= 1'b0;
      drop_count_reg <= 8'd0;
    end else begin
      state_reg    <= state_next;
      out_load_reg <= load_next;
      drop_err_reg <= drop_next;
      // Data and select hold between dispatches so the demux input stays stable.
      if (load_next != 3'b000) begin
        out_data_reg <= head_data;
        out_sel_reg  <= head_dest;
      end
      if (drop_next && (drop_count_reg != 8'hFF)) begin
        drop_count_reg <= drop_count_reg + 8'd1;
      end
    end
  end

  assign out_data   = out_data_reg;
  assign out_sel    = out_sel_reg;
  assign out_load   = out_load_reg;
  assign drop_err   = drop_err_reg;
  assign drop_count = drop_count_reg;

endmodule

// File: tb/tb_demux_dispatch_queue.sv
// Directed testbench for demux_dispatch_queue: scenario tasks with inline
// checks against hand-computed values.
module tb_demux_dispatch_queue;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] in_dest;
  logic [7:0] in_data;
  logic       flush;
  logic [2:0] dest_busy;
  logic [7:0] out_data;
  logic [1:0] out_sel;
  logic [2:0] out_load;
  logic       drop_err;
  logic [7:0] drop_count;
  logic [2:0] count;
  logic       empty;
  logic       full;

  int tests_run    = 0;
  int tests_failed = 0;

  demux_dispatch_queue #(.DEPTH(4), .DW(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_dest    (in_dest),
    .in_data    (in_data),
    .flush      (flush),
    .dest_busy  (dest_busy),
    .out_data   (out_data),
    .out_sel    (out_sel),
    .out_load   (out_load),
    .drop_err   (drop_err),
    .drop_count (drop_count),
    .count      (count),
    .empty      (empty),
    .full       (full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] d, input logic [7:0] x);
    in_valid = v;
    in_dest  = d;
    in_data  = x;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; dest_busy = 3'b000;
    drive(1'b0, 2'b00, 8'h00);
    repeat (2) @(posedge clk);
    #1;
    tests_run++; if (count !== 3'd0) begin tests_failed++; $display("FAIL reset_count got=%0d want=0", count); end
    tests_run++; if (empty !== 1'b1 || full !== 1'b0 || in_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_flags got empty=%b full=%b ready=%b want 1 0 1", empty, full, in_ready); end
    tests_run++; if (out_load !== 3'b000 || out_sel !== 2'b00 || out_data !== 8'h00) begin tests_failed++; $display("FAIL reset_out got load=%b sel=%b data=%h want 000 00 00", out_load, out_sel, out_data); end
    tests_run++; if (drop_err !== 1'b0 || drop_count !== 8'd0) begin tests_failed++; $display("FAIL reset_drop got err=%b cnt=%0d want 0 0", drop_err, drop_count); end
    rst = 1'b0;
    $display("[TB] reset: count=%0d empty=%b out_load=%b", count, empty, out_load);
  endtask

  task automatic test_single();
    drive(1'b1, 2'b01, 8'h05);
    tick();
    drive(1'b0, 2'b00, 8'h00);
    tests_run++; if (count !== 3'd1 || out_load !== 3'b000) begin tests_failed++; $display("FAIL single_accept got count=%0d load=%b want 1 000", count, out_load); end
    tick();
    tests_run++; if (out_load !== 3'b001 || out_sel !== 2'b01 || out_data !== 8'h05) begin tests_failed++; $display("FAIL single_issue got load=%b sel=%b data=%h want 001 01 05", out_load, out_sel, out_data); end
    tests_run++; if (count !== 3'd0) begin tests_failed++; $display("FAIL single_count got=%0d want=0", count); end
    tick();
    tests_run++; if (out_load !== 3'b000 || out_data !== 8'h05) begin tests_failed++; $display("FAIL single_hold got load=%b data=%h want 000 05", out_load, out_data); end
    $display("[TB] single: {01,05} load=001 sel=01 data=05");
  endtask

  task automatic test_back_to_back();
    logic [1:0] d_tab [4];
    logic [7:0] x_tab [4];
    logic [2:0] exp_load [5];
    d_tab = '{2'b01, 2'b10, 2'b11, 2'b11};
    x_tab = '{8'h05, 8'h05, 8'h05, 8'h0F};
    exp_load = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b100};
    for (int i = 0; i < 5; i++) begin
      if (i < 4) drive(1'b1, d_tab[i], x_tab[i]);
      else       drive(1'b0, 2'b00, 8'h00);
      tick();
      tests_run++; if (out_load !== exp_load[i]) begin tests_failed++; $display("FAIL b2b_load[%0d] got=%b want=%b", i, out_load, exp_load[i]); end
      $display("[TB] b2b cycle %0d: out_load=%b out_data=%h", i, out_load, out_data);
    end
    tests_run++; if (out_data !== 8'h0F || out_sel !== 2'b11 || count !== 3'd0) begin tests_failed++; $display("FAIL b2b_last got data=%h sel=%b count=%0d want 0f 11 0", out_data, out_sel, count); end
    tick();
  endtask

  task automatic test_hol_block();
    dest_busy = 3'b010;
    drive(1'b1, 2'b10, 8'hAA);
    tick();
    drive(1'b1, 2'b01, 8'h11);
    tick();
    drive(1'b0, 2'b00, 8'h00);
    for (int i = 0; i < 5; i++) begin
      tests_run++; if (out_load !== 3'b000 || full !== 1'b0 || count !== 3'd2) begin tests_failed++; $display("FAIL hol_wait[%0d] got load=%b full=%b count=%0d want 000 0 2", i, out_load, full, count); end
      tick();
    end
    dest_busy = 3'b000;
    tick();
    tests_run++; if (out_load !== 3'b010 || out_data !== 8'hAA) begin tests_failed++; $display("FAIL hol_first got load=%b data=%h want 010 aa", out_load, out_data); end
    tick();
    tests_run++; if (out_load !== 3'b001 || out_data !== 8'h11) begin tests_failed++; $display("FAIL hol_second got load=%b data=%h want 001 11", out_load, out_data); end
    tick();
    tests_run++; if (out_load !== 3'b000 || count !== 3'd0) begin tests_failed++; $display("FAIL hol_done got load=%b count=%0d want 000 0", out_load, count); end
    $display("[TB] hol: released busy, strobes 010 then 001");
  endtask

  task automatic test_full_flush();
    dest_busy = 3'b111;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 2'(i % 3 + 1), 8'(8'h20 + i));
      tick();
    end
    tests_run++; if (full !== 1'b1 || in_ready !== 1'b0 || count !== 3'd4) begin tests_failed++; $display("FAIL full_flags got full=%b ready=%b count=%0d want 1 0 4", full, in_ready, count); end
    drive(1'b1, 2'b01, 8'h99);
    tick();
    tests_run++; if (count !== 3'd4 || out_load !== 3'b000) begin tests_failed++; $display("FAIL full_5th got count=%0d load=%b want 4 000", count, out_load); end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    drive(1'b0, 2'b00, 8'h00);
    tests_run++; if (count !== 3'd0 || empty !== 1'b1 || full !== 1'b0) begin tests_failed++; $display("FAIL flush_clear got count=%0d empty=%b full=%b want 0 1 0", count, empty, full); end
    dest_busy = 3'b000;
    for (int i = 0; i < 3; i++) begin
      tick();
      tests_run++; if (out_load !== 3'b000) begin tests_failed++; $display("FAIL flush_nostrobe[%0d] got=%b want=000", i, out_load); end
    end
    $display("[TB] full/flush: count=%0d empty=%b", count, empty);
  endtask

  task automatic test_drop();
    int stray;
    drive(1'b1, 2'b00, 8'h33);
    tick();
    drive(1'b1, 2'b01, 8'h44);
    tick();
    drive(1'b0, 2'b00, 8'h00);
    tests_run++; if (drop_err !== 1'b1 || drop_count !== 8'd1) begin tests_failed++; $display("FAIL drop_pulse got err=%b cnt=%0d want 1 1", drop_err, drop_count); end
    tests_run++; if (out_load !== 3'b000 || out_data !== 8'h11 || out_sel !== 2'b01) begin tests_failed++; $display("FAIL drop_hold got load=%b data=%h sel=%b want 000 11 01", out_load, out_data, out_sel); end
    tick();
    tests_run++; if (out_load !== 3'b001 || out_data !== 8'h44 || drop_err !== 1'b0) begin tests_failed++; $display("FAIL drop_next got load=%b data=%h err=%b want 001 44 0", out_load, out_data, drop_err); end
    stray = 0;
    for (int i = 0; i < 300; i++) begin
      drive(1'b1, 2'b00, 8'(i));
      tick();
      if (out_load !== 3'b000 && i > 0) stray++;
      if (i == 99) begin
        tests_run++; if (drop_count !== 8'd100) begin tests_failed++; $display("FAIL drop_mid got=%0d want=100", drop_count); end
      end
    end
    drive(1'b0, 2'b00, 8'h00);
    tick();
    tick();
    tests_run++; if (drop_count !== 8'd255 || drop_err !== 1'b0) begin tests_failed++; $display("FAIL drop_sat got cnt=%0d err=%b want 255 0", drop_count, drop_err); end
    tests_run++; if (stray != 0) begin tests_failed++; $display("FAIL drop_stray got=%0d strobes want=0", stray); end
    $display("[TB] drop: drop_count=%0d", drop_count);
  endtask

  task automatic test_reset_mid();
    dest_busy = 3'b010;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 2'b10, 8'(i + 1));
      tick();
    end
    drive(1'b0, 2'b00, 8'h00);
    dest_busy = 3'b000;
    tick();
    tests_run++; if (out_load !== 3'b010 || count !== 3'd3 || out_data !== 8'h01) begin tests_failed++; $display("FAIL rstmid_setup got load=%b count=%0d data=%h want 010 3 01", out_load, count, out_data); end
    #2 rst = 1'b1;
    #1;
    tests_run++; if (out_load !== 3'b000 || count !== 3'd0 || empty !== 1'b1) begin tests_failed++; $display("FAIL rstmid_async got load=%b count=%0d empty=%b want 000 0 1", out_load, count, empty); end
    tests_run++; if (out_data !== 8'h00 || out_sel !== 2'b00 || drop_count !== 8'd0) begin tests_failed++; $display("FAIL rstmid_regs got data=%h sel=%b cnt=%0d want 00 00 0", out_data, out_sel, drop_count); end
    #2 rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      tests_run++; if (out_load !== 3'b000 || count !== 3'd0) begin tests_failed++; $display("FAIL rstmid_after[%0d] got load=%b count=%0d want 000 0", i, out_load, count); end
    end
    $display("[TB] reset mid-stream: out_load=%b count=%0d", out_load, count);
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_hol_block();
    test_full_flush();
    test_drop();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
